// File: rtl/arfs_pkg.sv
// Shared types for the ARFS steering-table controller.
package arfs_pkg;

  localparam int VLAN_W_DEF = 12;
  localparam int QID_W_DEF  = 11;

  // Update opcodes; the reserved encoding behaves like flush.
  typedef enum logic [1:0] {
    OP_INSERT = 2'b00,
    OP_DELETE = 2'b01,
    OP_FLUSH  = 2'b10,
    OP_RSVD   = 2'b11
  } arfs_op_e;

  // Update completion status.
  typedef enum logic [1:0] {
    ST_OK_NEW      = 2'b00,
    ST_OK_REPLACED = 2'b01,
    ST_NOT_FOUND   = 2'b10,
    ST_FULL        = 2'b11
  } arfs_status_e;

  // Table access FSM.
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_LKP_RSP  = 2'b01,
    S_UPD_EXEC = 2'b10,
    S_UPD_RSP  = 2'b11
  } arfs_state_e;

  // One table entry at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [VLAN_W_DEF-1:0] vlan;
    logic [QID_W_DEF-1:0]  qid;
  } arfs_entry_t;

  // Round-robin memory of which requester was served last.
  localparam logic GRANT_LKP = 1'b0;
  localparam logic GRANT_UPD = 1'b1;

endpackage

// File: rtl/arfs_match.sv
// Parallel key compare over the table plus lowest-free-slot search.
module arfs_match
  import arfs_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int VLAN_W      = 12,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] valid_i,
  input  logic [VLAN_W-1:0]      vlan_i [NUM_ENTRIES],
  input  logic [VLAN_W-1:0]      key_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       hit_idx_o,
  output logic                   free_o,
  output logic [IDX_W-1:0]       free_idx_o
);

  // Scan from the top so the lowest free index wins; keys are unique so at most one hit.
  always_comb begin
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    free_o     = 1'b0;
    free_idx_o = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_i[i] && (vlan_i[i] == key_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end else begin
        hit_o     = hit_o;
        hit_idx_o = hit_idx_o;
      end
      if (!valid_i[i]) begin
        free_o     = 1'b1;
        free_idx_o = IDX_W'(i);
      end else begin
        free_o     = free_o;
        free_idx_o = free_idx_o;
      end
    end
  end

endmodule

// File: rtl/arfs_table_ctrl.sv
// ARFS VLAN->QID steering table: one FSM serializes lookups and updates
// with round-robin arbitration so lookups always see committed updates.
module arfs_table_ctrl
  import arfs_pkg::*;
#(
  parameter int          NUM_ENTRIES = 16,
  parameter int          VLAN_W      = 12,
  parameter int          QID_W       = 11,
  parameter int unsigned DEFAULT_QID = 0,
  localparam int         IDX_W       = $clog2(NUM_ENTRIES),
  localparam int         CNT_W       = $clog2(NUM_ENTRIES) + 1
) (
  input  logic              axis_aclk,
  input  logic              axis_reset,
  input  logic              lkp_req_valid,
  output logic              lkp_req_ready,
  input  logic [VLAN_W-1:0] lkp_req_vlan,
  output logic              lkp_rsp_valid,
  input  logic              lkp_rsp_ready,
  output logic [QID_W-1:0]  lkp_rsp_qid,
  output logic              lkp_rsp_hit,
  input  logic              upd_req_valid,
  output logic              upd_req_ready,
  input  logic [1:0]        upd_req_op,
  input  logic [VLAN_W-1:0] upd_req_vlan,
  input  logic [QID_W-1:0]  upd_req_qid,
  output logic              upd_rsp_valid,
  input  logic              upd_rsp_ready,
  output logic [1:0]        upd_rsp_status,
  output logic [CNT_W-1:0]  tbl_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [QID_W-1:0] DEF_QID = QID_W'(DEFAULT_QID);

  arfs_state_e             state_q;
  logic                    last_grant_q;
  logic [NUM_ENTRIES-1:0]  tbl_valid_q;
  logic [VLAN_W-1:0]       tbl_vlan_q [NUM_ENTRIES];
  logic [QID_W-1:0]        tbl_qid_q  [NUM_ENTRIES];
  logic [CNT_W-1:0]        tbl_count_q;
  logic                    lkp_rsp_valid_q;
  logic [QID_W-1:0]        lkp_rsp_qid_q;
  logic                    lkp_rsp_hit_q;
  logic                    upd_rsp_valid_q;
  arfs_status_e            upd_rsp_status_q;
  arfs_op_e                upd_op_q;
  logic [VLAN_W-1:0]       upd_vlan_q;
  logic [QID_W-1:0]        upd_qid_q;

  logic                    grant_lkp_s;
  logic                    grant_upd_s;
  logic                    idle_s;
  logic [VLAN_W-1:0]       key_s;
  logic                    hit_s;
  logic [IDX_W-1:0]        hit_idx_s;
  logic                    free_s;
  logic [IDX_W-1:0]        free_idx_s;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign grant_lkp_s   = lkp_req_valid && (!upd_req_valid || (last_grant_q == GRANT_UPD));
  assign grant_upd_s   = upd_req_valid && !grant_lkp_s;
  assign idle_s        = (state_q == S_IDLE) && !axis_reset;
  assign lkp_req_ready = idle_s && grant_lkp_s;
  assign upd_req_ready = idle_s && grant_upd_s;

  // The single matcher sees the latched update key while executing, else the lookup key.
  assign key_s = (state_q == S_UPD_EXEC) ? upd_vlan_q : lkp_req_vlan;

  arfs_match #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VLAN_W      (VLAN_W)
  ) u_match (
    .valid_i    (tbl_valid_q),
    .vlan_i     (tbl_vlan_q),
    .key_i      (key_s),
    .hit_o      (hit_s),
    .hit_idx_o  (hit_idx_s),
    .free_o     (free_s),
    .free_idx_o (free_idx_s)
  );

  assign lkp_rsp_valid  = lkp_rsp_valid_q;
  assign lkp_rsp_qid    = lkp_rsp_qid_q;
  assign lkp_rsp_hit    = lkp_rsp_hit_q;
  assign upd_rsp_valid  = upd_rsp_valid_q;
  assign upd_rsp_status = upd_rsp_status_q;
  assign tbl_count      = tbl_count_q;

  // Access FSM: arbitration, registered responses and the table write port.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q          <= S_IDLE;
      last_grant_q     <= GRANT_UPD;
      tbl_valid_q      <= '0;
      tbl_count_q      <= '0;
      lkp_rsp_valid_q  <= 1'b0;
      lkp_rsp_qid_q    <= DEF_QID;
      lkp_rsp_hit_q    <= 1'b0;
      upd_rsp_valid_q  <= 1'b0;
      upd_rsp_status_q <= ST_OK_NEW;
      upd_op_q         <= OP_INSERT;
      upd_vlan_q       <= '0;
      upd_qid_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lkp_req_ready) begin
            lkp_rsp_qid_q   <= hit_s ? tbl_qid_q[hit_idx_s] : DEF_QID;
            lkp_rsp_hit_q   <= hit_s;
            lkp_rsp_valid_q <= 1'b1;
            last_grant_q    <= GRANT_LKP;
            state_q         <= S_LKP_RSP;
          end else if (upd_req_ready) begin
            upd_op_q     <= arfs_op_e'(upd_req_op);
            upd_vlan_q   <= upd_req_vlan;
            upd_qid_q    <= upd_req_qid;
            last_grant_q <= GRANT_UPD;
            state_q      <= S_UPD_EXEC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LKP_RSP: begin
          if (lkp_rsp_ready) begin
            lkp_rsp_valid_q <= 1'b0;
            state_q         <= S_IDLE;
          end else begin
            state_q <= S_LKP_RSP;
          end
        end
        S_UPD_EXEC: begin
          case (upd_op_q)
            OP_INSERT: begin
              if (hit_s) begin
                tbl_qid_q[hit_idx_s] <= upd_qid_q;
                upd_rsp_status_q     <= ST_OK_REPLACED;
              end else if (free_s) begin
                tbl_valid_q[free_idx_s] <= 1'b1;
                tbl_vlan_q[free_idx_s]  <= upd_vlan_q;
                tbl_qid_q[free_idx_s]   <= upd_qid_q;
                tbl_count_q             <= tbl_count_q + CNT_ONE;
                upd_rsp_status_q        <= ST_OK_NEW;
              end else begin
                upd_rsp_status_q <= ST_FULL;
              end
            end
            OP_DELETE: begin
              if (hit_s) begin
                tbl_valid_q[hit_idx_s] <= 1'b0;
                tbl_count_q            <= tbl_count_q - CNT_ONE;
                upd_rsp_status_q       <= ST_OK_NEW;
              end else begin
                upd_rsp_status_q <= ST_NOT_FOUND;
              end
            end
            default: begin
              tbl_valid_q      <= '0;
              tbl_count_q      <= '0;
              upd_rsp_status_q <= ST_OK_NEW;
            end
          endcase
          upd_rsp_valid_q <= 1'b1;
          state_q         <= S_UPD_RSP;
        end
        S_UPD_RSP: begin
          if (upd_rsp_ready) begin
            upd_rsp_valid_q <= 1'b0;
            state_q         <= S_IDLE;
          end else begin
            state_q <= S_UPD_RSP;
          end
        end
        default: begin
          lkp_rsp_valid_q <= 1'b0;
          upd_rsp_valid_q <= 1'b0;
          state_q         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arfs_table_ctrl.sv
// Directed bench for arfs_table_ctrl: vector table plus arbitration/stall/reset sequences.
module tb_arfs_table_ctrl;

  localparam int NUM_ENTRIES = 16;
  localparam int VLAN_W      = 12;
  localparam int QID_W       = 11;
  localparam int CNT_W       = $clog2(NUM_ENTRIES) + 1;

  logic              axis_aclk;
  logic              axis_reset;
  logic              lkp_req_valid;
  logic              lkp_req_ready;
  logic [VLAN_W-1:0] lkp_req_vlan;
  logic              lkp_rsp_valid;
  logic              lkp_rsp_ready;
  logic [QID_W-1:0]  lkp_rsp_qid;
  logic              lkp_rsp_hit;
  logic              upd_req_valid;
  logic              upd_req_ready;
  logic [1:0]        upd_req_op;
  logic [VLAN_W-1:0] upd_req_vlan;
  logic [QID_W-1:0]  upd_req_qid;
  logic              upd_rsp_valid;
  logic              upd_rsp_ready;
  logic [1:0]        upd_rsp_status;
  logic [CNT_W-1:0]  tbl_count;

  arfs_table_ctrl #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VLAN_W      (VLAN_W),
    .QID_W       (QID_W),
    .DEFAULT_QID (0)
  ) dut (
    .axis_aclk      (axis_aclk),
    .axis_reset     (axis_reset),
    .lkp_req_valid  (lkp_req_valid),
    .lkp_req_ready  (lkp_req_ready),
    .lkp_req_vlan   (lkp_req_vlan),
    .lkp_rsp_valid  (lkp_rsp_valid),
    .lkp_rsp_ready  (lkp_rsp_ready),
    .lkp_rsp_qid    (lkp_rsp_qid),
    .lkp_rsp_hit    (lkp_rsp_hit),
    .upd_req_valid  (upd_req_valid),
    .upd_req_ready  (upd_req_ready),
    .upd_req_op     (upd_req_op),
    .upd_req_vlan   (upd_req_vlan),
    .upd_req_qid    (upd_req_qid),
    .upd_rsp_valid  (upd_rsp_valid),
    .upd_rsp_ready  (upd_rsp_ready),
    .upd_rsp_status (upd_rsp_status),
    .tbl_count      (tbl_count)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct {
    bit          is_upd;
    logic [1:0]  op;
    logic [11:0] vlan;
    logic [10:0] qid;
    logic        exp_hit;
    logic [10:0] exp_qid;
    logic [1:0]  exp_status;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t lk(input logic [11:0] v, input logic h, input logic [10:0] q,
                              input logic [4:0] c);
    vec_t r;
    r = '{is_upd: 1'b0, op: 2'b00, vlan: v, qid: 11'h000, exp_hit: h, exp_qid: q,
          exp_status: 2'b00, exp_count: c};
    return r;
  endfunction

  function automatic vec_t up(input logic [1:0] o, input logic [11:0] v, input logic [10:0] q,
                              input logic [1:0] s, input logic [4:0] c);
    vec_t r;
    r = '{is_upd: 1'b1, op: o, vlan: v, qid: q, exp_hit: 1'b0, exp_qid: 11'h000,
          exp_status: s, exp_count: c};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge axis_aclk);
    axis_reset    = 1'b1;
    lkp_req_valid = 1'b0;
    upd_req_valid = 1'b0;
    lkp_rsp_ready = 1'b0;
    upd_rsp_ready = 1'b0;
    repeat (2) @(posedge axis_aclk);
    #1 axis_reset = 1'b0;
  endtask

  task automatic do_lookup(input logic [11:0] v, output logic hit, output logic [10:0] qid);
    int waitc;
    waitc = 0;
    hit   = 1'b0;
    qid   = 11'h7FF;
    @(negedge axis_aclk);
    lkp_req_vlan  = v;
    lkp_req_valid = 1'b1;
    #1;
    while (!lkp_req_ready && waitc < 50) begin
      @(negedge axis_aclk);
      waitc++;
    end
    if (!lkp_req_ready) begin
      timeout_fail("lkp_grant");
      lkp_req_valid = 1'b0;
      return;
    end
    @(posedge axis_aclk);
    #1 lkp_req_valid = 1'b0;
    @(negedge axis_aclk);
    check("lkp_rsp_valid", 32'(lkp_rsp_valid), 32'd1);
    hit = lkp_rsp_hit;
    qid = lkp_rsp_qid;
    lkp_rsp_ready = 1'b1;
    @(posedge axis_aclk);
    #1 lkp_rsp_ready = 1'b0;
  endtask

  task automatic do_update(input logic [1:0] o, input logic [11:0] v, input logic [10:0] q,
                           output logic [1:0] st);
    int waitc;
    waitc = 0;
    st    = 2'bxx;
    @(negedge axis_aclk);
    upd_req_op    = o;
    upd_req_vlan  = v;
    upd_req_qid   = q;
    upd_req_valid = 1'b1;
    #1;
    while (!upd_req_ready && waitc < 50) begin
      @(negedge axis_aclk);
      waitc++;
    end
    if (!upd_req_ready) begin
      timeout_fail("upd_grant");
      upd_req_valid = 1'b0;
      return;
    end
    @(posedge axis_aclk);
    #1 upd_req_valid = 1'b0;
    @(negedge axis_aclk);
    check("upd_rsp_early", 32'(upd_rsp_valid), 32'd0);
    @(negedge axis_aclk);
    check("upd_rsp_valid", 32'(upd_rsp_valid), 32'd1);
    st = upd_rsp_status;
    upd_rsp_ready = 1'b1;
    @(posedge axis_aclk);
    #1 upd_rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hit;
    logic [10:0] qid;
    logic [1:0]  st;
    int          g_who [8];
    int          g_cyc [8];
    int          grants;
    int          cyc;
    logic        l_hit [8];
    logic [10:0] l_qid [8];
    int          n_l;
    logic [1:0]  u_st [8];
    int          n_u;

    axis_reset    = 1'b1;
    lkp_req_valid = 1'b0;
    lkp_req_vlan  = 12'h000;
    lkp_rsp_ready = 1'b0;
    upd_req_valid = 1'b0;
    upd_req_op    = 2'b00;
    upd_req_vlan  = 12'h000;
    upd_req_qid   = 11'h000;
    upd_rsp_ready = 1'b0;

    do_reset();
    @(negedge axis_aclk);
    check("rst_lkp_rsp_valid", 32'(lkp_rsp_valid), 32'd0);
    check("rst_upd_rsp_valid", 32'(upd_rsp_valid), 32'd0);
    check("rst_lkp_req_ready", 32'(lkp_req_ready), 32'd0);
    check("rst_upd_req_ready", 32'(upd_req_ready), 32'd0);
    check("rst_lkp_rsp_qid", 32'(lkp_rsp_qid), 32'd0);
    check("rst_lkp_rsp_hit", 32'(lkp_rsp_hit), 32'd0);
    check("rst_upd_rsp_status", 32'(upd_rsp_status), 32'd0);
    check("rst_tbl_count", 32'(tbl_count), 32'd0);

    // Vector table: ops 00 ins, 01 del, 10 flush, 11 reserved; status 00 new, 01 repl, 10 nf, 11 full.
    vecs.push_back(lk(12'h0F0, 1'b0, 11'h000, 5'd0));
    vecs.push_back(up(2'b00, 12'h0F0, 11'h0FA, 2'b00, 5'd1));
    vecs.push_back(lk(12'h0F0, 1'b1, 11'h0FA, 5'd1));
    vecs.push_back(up(2'b00, 12'h0F0, 11'h0FB, 2'b01, 5'd1));
    vecs.push_back(lk(12'h0F0, 1'b1, 11'h0FB, 5'd1));
    vecs.push_back(up(2'b10, 12'h000, 11'h000, 2'b00, 5'd0));
    vecs.push_back(lk(12'h0F0, 1'b0, 11'h000, 5'd0));
    vecs.push_back(up(2'b01, 12'h0F0, 11'h000, 2'b10, 5'd0));
    for (int i = 1; i <= 16; i++) begin
      vecs.push_back(up(2'b00, 12'(i), 11'(32'h100 + i), 2'b00, 5'(i)));
    end
    vecs.push_back(up(2'b00, 12'd17, 11'h2AA, 2'b11, 5'd16));
    vecs.push_back(lk(12'd17, 1'b0, 11'h000, 5'd16));
    vecs.push_back(up(2'b01, 12'd5, 11'h000, 2'b00, 5'd15));
    vecs.push_back(lk(12'd5, 1'b0, 11'h000, 5'd15));
    vecs.push_back(up(2'b00, 12'd17, 11'h2AA, 2'b00, 5'd16));
    vecs.push_back(lk(12'd17, 1'b1, 11'h2AA, 5'd16));
    vecs.push_back(lk(12'd16, 1'b1, 11'h110, 5'd16));
    vecs.push_back(lk(12'd4, 1'b1, 11'h104, 5'd16));
    vecs.push_back(lk(12'd6, 1'b1, 11'h106, 5'd16));
    vecs.push_back(up(2'b01, 12'd99, 11'h000, 2'b10, 5'd16));
    vecs.push_back(up(2'b00, 12'd18, 11'h033, 2'b11, 5'd16));
    vecs.push_back(up(2'b11, 12'h000, 11'h000, 2'b00, 5'd0));
    vecs.push_back(lk(12'd1, 1'b0, 11'h000, 5'd0));
    vecs.push_back(lk(12'd17, 1'b0, 11'h000, 5'd0));

    foreach (vecs[k]) begin
      if (vecs[k].is_upd) begin
        do_update(vecs[k].op, vecs[k].vlan, vecs[k].qid, st);
        check($sformatf("vec%0d_status", k), 32'(st), 32'(vecs[k].exp_status));
        check($sformatf("vec%0d_count", k), 32'(tbl_count), 32'(vecs[k].exp_count));
      end else begin
        do_lookup(vecs[k].vlan, hit, qid);
        check($sformatf("vec%0d_hit", k), 32'(hit), 32'(vecs[k].exp_hit));
        check($sformatf("vec%0d_qid", k), 32'(qid), 32'(vecs[k].exp_qid));
        check($sformatf("vec%0d_count", k), 32'(tbl_count), 32'(vecs[k].exp_count));
      end
    end

    // Both requesters valid continuously: lookup first after reset, then alternate.
    do_reset();
    grants = 0;
    cyc    = 0;
    n_l    = 0;
    n_u    = 0;
    lkp_req_vlan  = 12'h0F0;
    upd_req_op    = 2'b00;
    upd_req_vlan  = 12'h0F0;
    upd_req_qid   = 11'h055;
    lkp_rsp_ready = 1'b1;
    upd_rsp_ready = 1'b1;
    lkp_req_valid = 1'b1;
    upd_req_valid = 1'b1;
    while (grants < 4 && cyc < 40) begin
      @(negedge axis_aclk);
      if (lkp_req_ready && upd_req_ready) begin
        check("arb_both_ready", 32'd1, 32'd0);
      end
      if (lkp_rsp_valid && n_l < 8) begin
        l_hit[n_l] = lkp_rsp_hit;
        l_qid[n_l] = lkp_rsp_qid;
        n_l++;
      end
      if (upd_rsp_valid && n_u < 8) begin
        u_st[n_u] = upd_rsp_status;
        n_u++;
      end
      if (lkp_req_ready) begin
        g_who[grants] = 0;
        g_cyc[grants] = cyc;
        grants++;
      end else if (upd_req_ready) begin
        g_who[grants] = 1;
        g_cyc[grants] = cyc;
        grants++;
      end
      cyc++;
    end
    @(posedge axis_aclk);
    #1;
    lkp_req_valid = 1'b0;
    upd_req_valid = 1'b0;
    repeat (6) begin
      @(negedge axis_aclk);
      if (lkp_rsp_valid && n_l < 8) begin
        l_hit[n_l] = lkp_rsp_hit;
        l_qid[n_l] = lkp_rsp_qid;
        n_l++;
      end
      if (upd_rsp_valid && n_u < 8) begin
        u_st[n_u] = upd_rsp_status;
        n_u++;
      end
    end
    check("arb_grants", 32'(grants), 32'd4);
    if (grants == 4) begin
      check("arb_who0", 32'(g_who[0]), 32'd0);
      check("arb_who1", 32'(g_who[1]), 32'd1);
      check("arb_who2", 32'(g_who[2]), 32'd0);
      check("arb_who3", 32'(g_who[3]), 32'd1);
      check("arb_cyc1", 32'(g_cyc[1] - g_cyc[0]), 32'd2);
      check("arb_cyc2", 32'(g_cyc[2] - g_cyc[1]), 32'd3);
      check("arb_cyc3", 32'(g_cyc[3] - g_cyc[2]), 32'd2);
    end
    check("arb_n_lkp_rsp", 32'(n_l), 32'd2);
    check("arb_n_upd_rsp", 32'(n_u), 32'd2);
    if (n_l == 2) begin
      check("arb_lkp0_hit", 32'(l_hit[0]), 32'd0);
      check("arb_lkp1_hit", 32'(l_hit[1]), 32'd1);
      check("arb_lkp1_qid", 32'(l_qid[1]), 32'h055);
    end
    if (n_u == 2) begin
      check("arb_upd0_st", 32'(u_st[0]), 32'd0);
      check("arb_upd1_st", 32'(u_st[1]), 32'd1);
    end
    check("arb_count", 32'(tbl_count), 32'd1);

    // Lookup response back-pressured for 5 cycles while an update waits.
    lkp_rsp_ready = 1'b0;
    upd_rsp_ready = 1'b1;
    lkp_req_vlan  = 12'h0F0;
    upd_req_op    = 2'b00;
    upd_req_vlan  = 12'h0A0;
    upd_req_qid   = 11'h011;
    lkp_req_valid = 1'b1;
    upd_req_valid = 1'b1;
    #1;
    check("stall_lkp_granted", 32'(lkp_req_ready), 32'd1);
    check("stall_upd_not_granted", 32'(upd_req_ready), 32'd0);
    @(posedge axis_aclk);
    #1 lkp_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge axis_aclk);
      check($sformatf("stall%0d_valid", c), 32'(lkp_rsp_valid), 32'd1);
      check($sformatf("stall%0d_qid", c), 32'(lkp_rsp_qid), 32'h055);
      check($sformatf("stall%0d_hit", c), 32'(lkp_rsp_hit), 32'd1);
      check($sformatf("stall%0d_upd_ready", c), 32'(upd_req_ready), 32'd0);
    end
    lkp_rsp_ready = 1'b1;
    @(posedge axis_aclk);
    #1 lkp_rsp_ready = 1'b0;
    @(negedge axis_aclk);
    check("stall_upd_granted", 32'(upd_req_ready), 32'd1);
    @(posedge axis_aclk);
    #1 upd_req_valid = 1'b0;
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    check("stall_upd_rsp_valid", 32'(upd_rsp_valid), 32'd1);
    check("stall_upd_status", 32'(upd_rsp_status), 32'd0);
    check("stall_count", 32'(tbl_count), 32'd2);
    @(posedge axis_aclk);
    #1 upd_rsp_ready = 1'b0;

    // Reset while an update response is pending.
    @(negedge axis_aclk);
    upd_req_op    = 2'b00;
    upd_req_vlan  = 12'h033;
    upd_req_qid   = 11'h0AB;
    upd_req_valid = 1'b1;
    #1;
    check("rstmid_upd_ready", 32'(upd_req_ready), 32'd1);
    @(posedge axis_aclk);
    #1 upd_req_valid = 1'b0;
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    check("rstmid_rsp_valid", 32'(upd_rsp_valid), 32'd1);
    check("rstmid_count_pre", 32'(tbl_count), 32'd3);
    axis_reset = 1'b1;
    @(negedge axis_aclk);
    check("rstmid_upd_valid_drop", 32'(upd_rsp_valid), 32'd0);
    check("rstmid_lkp_valid_drop", 32'(lkp_rsp_valid), 32'd0);
    check("rstmid_count", 32'(tbl_count), 32'd0);
    @(posedge axis_aclk);
    #1 axis_reset = 1'b0;
    do_lookup(12'h033, hit, qid);
    check("rstmid_lkp033_hit", 32'(hit), 32'd0);
    check("rstmid_lkp033_qid", 32'(qid), 32'd0);
    do_lookup(12'h0F0, hit, qid);
    check("rstmid_lkp0F0_hit", 32'(hit), 32'd0);
    check("rstmid_final_count", 32'(tbl_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
